// File: rtl/decode_queue_if.sv
// Handshake and decoded-field bundle between fetch, decode queue and execute.
// The decode queue connects through the slave modport; the producer/consumer side uses master.
interface decode_queue_if #(
  parameter int unsigned PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [31:0]     out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [PC_W-1:0] out_pc;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_fmt, out_illegal, out_pc
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_funct3, out_funct7,
           out_rd, out_rs1, out_rs2, out_imm, out_fmt, out_illegal, out_pc
  );
endinterface

// File: rtl/decode_queue.sv
// Buffered RV32I decode stage: decodes each instruction as it is pushed and stores
// the decoded fields in a DEPTH-entry FIFO so fetch can run ahead of a stalled back end.
module decode_queue #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PC_W     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  decode_queue_if.slave  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [31:0]     imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [31:0] w_instr;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm;
  logic [2:0]  w_fmt;
  logic        w_illegal;
  entry_t      w_dec;
  entry_t      w_head;
  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_push;
  logic        w_pop;

  assign w_instr = bus.in_instr;
  assign w_opc   = w_instr[6:0];
  assign w_f3    = w_instr[14:12];
  assign w_f7    = w_instr[31:25];

  // Format, immediate and legality of the word on the input port.
  always_comb begin : decode
    w_imm     = '0;
    w_fmt     = FMT_R;
    w_illegal = 1'b0;
    case (w_opc)
      OP_R: begin
        w_fmt = FMT_R;
        case (w_f7)
          F7_BASE: w_illegal = 1'b0;
          F7_ALT:  w_illegal = !((w_f3 == 3'b000) || (w_f3 == 3'b101));
          F7_MUL:  w_illegal = !ENABLE_M;
          default: w_illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        w_fmt = FMT_I;
        w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
        if (w_f3 == 3'b001) begin
          w_imm     = {27'b0, w_instr[24:20]};
          w_illegal = (w_f7 != F7_BASE);
        end else if (w_f3 == 3'b101) begin
          w_imm     = {27'b0, w_instr[24:20]};
          w_illegal = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
        end
      end
      OP_LOAD, OP_JALR, OP_SYSTEM: begin
        w_fmt = FMT_I;
        w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
      end
      OP_FENCE: begin
        w_fmt = FMT_I;
        w_imm = '0;
      end
      OP_STORE: begin
        w_fmt = FMT_S;
        w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
      end
      OP_BRANCH: begin
        w_fmt = FMT_B;
        w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                 w_instr[30:25], w_instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_fmt = FMT_U;
        w_imm = {w_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        w_fmt = FMT_J;
        w_imm = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                 w_instr[20], w_instr[30:21], 1'b0};
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_instr[1:0] != 2'b11) begin
      w_illegal = 1'b1;
    end
    // Illegal words still travel down the pipe, but with a neutral format and immediate.
    if (w_illegal) begin
      w_fmt = FMT_R;
      w_imm = '0;
    end
  end

  always_comb begin : pack_entry
    w_dec         = '0;
    w_dec.opcode  = w_opc;
    w_dec.funct3  = w_f3;
    w_dec.funct7  = w_f7;
    w_dec.rd      = w_instr[11:7];
    w_dec.rs1     = w_instr[19:15];
    w_dec.rs2     = w_instr[24:20];
    w_dec.imm     = w_imm;
    w_dec.fmt     = w_fmt;
    w_dec.illegal = w_illegal;
    w_dec.pc      = bus.in_pc;
  end

  // Ready ignores out_ready: a full queue never accepts, even on a same-cycle pop.
  assign w_in_ready  = !rst && (r_count < CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;

  // Queue state; reset clears storage so the outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = w_out_valid;
  assign bus.out_opcode  = w_head.opcode;
  assign bus.out_funct3  = w_head.funct3;
  assign bus.out_funct7  = w_head.funct7;
  assign bus.out_rd      = w_head.rd;
  assign bus.out_rs1     = w_head.rs1;
  assign bus.out_rs2     = w_head.rs2;
  assign bus.out_imm     = w_head.imm;
  assign bus.out_fmt     = w_head.fmt;
  assign bus.out_illegal = w_head.illegal;
  assign bus.out_pc      = w_head.pc;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: two instances (RV32M enabled / disabled) share
// one stimulus stream; every expected value below is hand-derived from the encodings.
module tb_decode_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  decode_queue_if #(.PC_W(32)) b0 ();
  decode_queue_if #(.PC_W(32)) b1 ();

  assign b0.flush     = flush;
  assign b0.in_valid  = in_valid;
  assign b0.in_instr  = in_instr;
  assign b0.in_pc     = in_pc;
  assign b0.out_ready = out_ready;
  assign b1.flush     = flush;
  assign b1.in_valid  = in_valid;
  assign b1.in_instr  = in_instr;
  assign b1.in_pc     = in_pc;
  assign b1.out_ready = out_ready;

  decode_queue #(.DEPTH(2), .PC_W(32), .ENABLE_M(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  decode_queue #(.DEPTH(2), .PC_W(32), .ENABLE_M(1'b0)) dut_nom (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();

    // reset state
    chk("rst_in_ready", 64'(b0.in_ready), 64'h0);
    chk("rst_out_valid", 64'(b0.out_valid), 64'h0);
    chk("rst_opcode", 64'(b0.out_opcode), 64'h0);
    chk("rst_imm", 64'(b0.out_imm), 64'h0);
    chk("rst_pc", 64'(b0.out_pc), 64'h0);
    chk("rst_fmt", 64'(b0.out_fmt), 64'h0);
    chk("rst_illegal", 64'(b0.out_illegal), 64'h0);
    chk("rst_nom_valid", 64'(b1.out_valid), 64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(b0.in_ready), 64'h1);

    // addi x1,x0,-1
    drive(1'b1, 32'hFFF00093, 32'h100);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("addi_valid", 64'(b0.out_valid), 64'h1);
    chk("addi_imm", 64'(b0.out_imm), 64'hFFFFFFFF);
    chk("addi_rd", 64'(b0.out_rd), 64'h1);
    chk("addi_rs1", 64'(b0.out_rs1), 64'h0);
    chk("addi_fmt", 64'(b0.out_fmt), 64'h1);
    chk("addi_illegal", 64'(b0.out_illegal), 64'h0);
    chk("addi_pc", 64'(b0.out_pc), 64'h100);
    chk("addi_opcode", 64'(b0.out_opcode), 64'h13);
    out_ready = 1'b1;
    tick();
    chk("addi_popped", 64'(b0.out_valid), 64'h0);

    // beq then jal streamed with out_ready held high
    drive(1'b1, 32'hFE000EE3, 32'h200);
    tick();
    chk("beq_valid", 64'(b0.out_valid), 64'h1);
    chk("beq_imm", 64'(b0.out_imm), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(b0.out_fmt), 64'h3);
    drive(1'b1, 32'h001000EF, 32'h204);
    tick();
    chk("jal_imm", 64'(b0.out_imm), 64'h00000800);
    chk("jal_rd", 64'(b0.out_rd), 64'h1);
    chk("jal_fmt", 64'(b0.out_fmt), 64'h5);
    chk("jal_pc", 64'(b0.out_pc), 64'h204);
    drive(1'b1, 32'h12345037, 32'h208);
    tick();
    chk("lui_imm", 64'(b0.out_imm), 64'h12345000);
    chk("lui_fmt", 64'(b0.out_fmt), 64'h4);
    drive(1'b1, 32'hFE20AE23, 32'h20C);
    tick();
    chk("sw_imm", 64'(b0.out_imm), 64'hFFFFFFFC);
    chk("sw_fmt", 64'(b0.out_fmt), 64'h2);
    chk("sw_rs1", 64'(b0.out_rs1), 64'h1);
    chk("sw_rs2", 64'(b0.out_rs2), 64'h2);
    chk("sw_funct3", 64'(b0.out_funct3), 64'h2);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("stream_drained", 64'(b0.out_valid), 64'h0);

    // slli / srai shamt decode, queued behind a stalled consumer
    out_ready = 1'b0;
    drive(1'b1, 32'h01F11113, 32'h300);
    tick();
    drive(1'b1, 32'h41F15113, 32'h304);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("shift_full", 64'(b0.in_ready), 64'h0);
    chk("slli_imm", 64'(b0.out_imm), 64'h1F);
    chk("slli_funct7", 64'(b0.out_funct7), 64'h00);
    chk("slli_illegal", 64'(b0.out_illegal), 64'h0);
    chk("slli_pc", 64'(b0.out_pc), 64'h300);
    out_ready = 1'b1;
    tick();
    chk("srai_imm", 64'(b0.out_imm), 64'h1F);
    chk("srai_funct7", 64'(b0.out_funct7), 64'h20);
    chk("srai_illegal", 64'(b0.out_illegal), 64'h0);
    chk("srai_pc", 64'(b0.out_pc), 64'h304);
    tick();
    chk("shift_drained", 64'(b0.out_valid), 64'h0);

    // mul legality depends on ENABLE_M; zero word and bad slli funct7 are illegal
    drive(1'b1, 32'h022081B3, 32'h400);
    tick();
    chk("mul_m_illegal", 64'(b0.out_illegal), 64'h0);
    chk("mul_m_rd", 64'(b0.out_rd), 64'h3);
    chk("mul_m_fmt", 64'(b0.out_fmt), 64'h0);
    chk("mul_nom_illegal", 64'(b1.out_illegal), 64'h1);
    chk("mul_nom_imm", 64'(b1.out_imm), 64'h0);
    drive(1'b1, 32'h00000000, 32'h404);
    tick();
    chk("zero_illegal", 64'(b0.out_illegal), 64'h1);
    chk("zero_pc", 64'(b0.out_pc), 64'h404);
    drive(1'b1, 32'h41F11113, 32'h408);
    tick();
    chk("badslli_illegal", 64'(b0.out_illegal), 64'h1);
    chk("badslli_imm", 64'(b0.out_imm), 64'h0);
    chk("badslli_fmt", 64'(b0.out_fmt), 64'h0);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("illegal_drained", 64'(b0.out_valid), 64'h0);

    // full queue holds off a third push; ready ignores a same-cycle pop
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h500);
    tick();
    chk("full_ready_1", 64'(b0.in_ready), 64'h1);
    drive(1'b1, 32'h00200093, 32'h504);
    tick();
    chk("full_ready_2", 64'(b0.in_ready), 64'h0);
    drive(1'b1, 32'h00300093, 32'h508);
    tick();
    chk("full_held_ready", 64'(b0.in_ready), 64'h0);
    chk("full_head_pc", 64'(b0.out_pc), 64'h500);
    out_ready = 1'b1;
    tick();
    chk("full_pop1_pc", 64'(b0.out_pc), 64'h504);
    chk("full_pop1_ready", 64'(b0.in_ready), 64'h1);
    tick();
    chk("full_third_pc", 64'(b0.out_pc), 64'h508);
    chk("full_third_imm", 64'(b0.out_imm), 64'h3);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("full_drained", 64'(b0.out_valid), 64'h0);

    // flush with a push and pop offered in the same cycle
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h600);
    tick();
    drive(1'b1, 32'h00100093, 32'h604);
    tick();
    chk("preflush_valid", 64'(b0.out_valid), 64'h1);
    flush     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h00700093, 32'h608);
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("flush_valid", 64'(b0.out_valid), 64'h0);
    chk("flush_ready", 64'(b0.in_ready), 64'h1);
    tick();
    chk("flush_word_gone", 64'(b0.out_valid), 64'h0);
    drive(1'b1, 32'h00500093, 32'h700);
    tick();
    drive(1'b1, 32'h00600093, 32'h704);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("postflush_full", 64'(b0.in_ready), 64'h0);
    chk("postflush_pc", 64'(b0.out_pc), 64'h700);
    chk("postflush_imm", 64'(b0.out_imm), 64'h5);

    // reset mid-stream with a push offered
    rst = 1'b1;
    drive(1'b1, 32'h00900093, 32'h800);
    tick();
    chk("midrst_ready", 64'(b0.in_ready), 64'h0);
    chk("midrst_valid", 64'(b0.out_valid), 64'h0);
    chk("midrst_pc", 64'(b0.out_pc), 64'h0);
    chk("midrst_imm", 64'(b0.out_imm), 64'h0);
    chk("midrst_rd", 64'(b0.out_rd), 64'h0);
    chk("midrst_opcode", 64'(b0.out_opcode), 64'h0);
    chk("midrst_nom_pc", 64'(b1.out_pc), 64'h0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("after_rst_ready", 64'(b0.in_ready), 64'h1);
    chk("after_rst_valid", 64'(b0.out_valid), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
